mem_port_arbiter: RTL and testbench

- Shares the single cache-line memory port between two requesters: the instruction fetch unit (I-side refill) and the load/store unit (D-side refill/writeback).
- Sits between both cache controllers and the memory/bus bridge.
- Arbitrates with round-robin and locks the grant for one whole transaction.
- Routes the response only to the owner and enforces a release cycle so a level-held request is never double-served.
- A watchdog aborts transactions that never complete.

---
 rtl/mem_port_arbiter_pkg.sv | 26 ++
 rtl/mem_port_arbiter_watchdog.sv | 38 +++
 rtl/mem_port_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter_pkg
//   Shared encodings for the I/D memory-port arbiter: arbiter state, grant
//   owner and the write-length codes carried on d_wlen / m_wlen.
// ----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_GNT_I   = 2'd1,
      ARB_GNT_D   = 2'd2,
      ARB_RELEASE = 2'd3
   } arb_state_e;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_e;

   // Write-length codes (2-bit field).
   localparam logic [1:0] WLEN_BYTE  = 2'd0;
   localparam logic [1:0] WLEN_HALF  = 2'd1;
   localparam logic [1:0] WLEN_WORD  = 2'd2;
   localparam logic [1:0] WLEN_DWORD = 2'd3;

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter_watchdog
//   Counts the cycles a granted transaction has been waiting for memory.
//   Ports:
//     clk, rstn : clock, asynchronous active-low reset
//     clr       : restart the count at 0 (issued on grant)
//     en        : count this cycle (granted, no completion)
//     expire    : count has reached TIMEOUT-1
// ----------------------------------------------------------------------------
module mem_port_arbiter_watchdog #(
   parameter int TIMEOUT = 1024,
   parameter int CNT_W   = 11
) (
   input  logic clk,
   input  logic rstn,
   input  logic clr,
   input  logic en,
   output logic expire
);

   logic [CNT_W-1:0] cnt;

   assign expire = (cnt == CNT_W'(TIMEOUT - 1));

   // NOTE: sequential state is written only with non-blocking assignments so
   // every register samples the pre-edge value of every other register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && !expire) begin
         // Saturate at the expiry value; the arbiter leaves GNT that cycle.
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one cache-line memory port between the I-side refill path and the
//   D-side refill/writeback path. Round-robin arbitration, grant held for a
//   whole transaction, response routed only to the owner, one RELEASE cycle
//   after every transaction, watchdog abort of stuck transactions.
//   Ports:
//     clk, rstn                      : clock, asynchronous active-low reset
//     i_addr, i_ren                  : I-side read request (level)
//     i_rdata, i_rvalid              : I-side read response (pulse)
//     d_addr, d_ren, d_wen,
//     d_wdata, d_wlen                : D-side read/write request (level)
//     d_rdata, d_rvalid, d_wready    : D-side response (pulses)
//     m_addr, m_ren, m_wen,
//     m_wdata, m_wlen                : memory request, valid only while granted
//     m_rdata, m_rvalid, m_wready    : memory response
//     err_timeout                    : one-cycle pulse on watchdog abort
//     busy                           : arbiter not in IDLE
// ----------------------------------------------------------------------------
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int LINE_W  = 64,
   parameter int WLEN_W  = 2,
   parameter int TIMEOUT = 1024,
   parameter int CNT_W   = 11
) (
   input  logic              clk,
   input  logic              rstn,
   // I-side
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_ren,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_rvalid,
   // D-side
   input  logic [ADDR_W-1:0] d_addr,
   input  logic              d_ren,
   input  logic              d_wen,
   input  logic [LINE_W-1:0] d_wdata,
   input  logic [WLEN_W-1:0] d_wlen,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_rvalid,
   output logic              d_wready,
   // Memory side
   output logic [ADDR_W-1:0] m_addr,
   output logic              m_ren,
   output logic              m_wen,
   output logic [LINE_W-1:0] m_wdata,
   output logic [WLEN_W-1:0] m_wlen,
   input  logic [LINE_W-1:0] m_rdata,
   input  logic              m_rvalid,
   input  logic              m_wready,
   // Status
   output logic              err_timeout,
   output logic              busy
);

   arb_state_e state, state_nx;
   owner_e     last_gnt, last_gnt_nx;

   logic req_i, req_d;
   logic grant;      // leaving IDLE this cycle
   logic xfer_done;  // owner's transaction completes this cycle
   logic in_gnt;
   logic expire;

   assign req_i  = i_ren;
   assign req_d  = d_ren | d_wen;
   assign in_gnt = (state == ARB_GNT_I) || (state == ARB_GNT_D);
   assign busy   = (state != ARB_IDLE);

   mem_port_arbiter_watchdog #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_watchdog (
      .clk    (clk),
      .rstn   (rstn),
      .clr    (grant),
      .en     (in_gnt && !xfer_done),
      .expire (expire)
   );

   // last_gnt resets to D so the first tie goes to I.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= ARB_IDLE;
         last_gnt <= OWN_D;
      end else begin
         state    <= state_nx;
         last_gnt <= last_gnt_nx;
      end
   end

   // NOTE: every signal driven here gets a default before the case statement;
   // a path that skips an assignment would otherwise infer a latch.
   always_comb begin
      state_nx    = state;
      last_gnt_nx = last_gnt;
      grant       = 1'b0;
      xfer_done   = 1'b0;
      m_addr      = '0;
      m_ren       = 1'b0;
      m_wen       = 1'b0;
      m_wdata     = '0;
      m_wlen      = '0;
      i_rdata     = '0;
      i_rvalid    = 1'b0;
      d_rdata     = '0;
      d_rvalid    = 1'b0;
      d_wready    = 1'b0;
      err_timeout = 1'b0;

      unique case (state)
         ARB_IDLE: begin
            // On a tie, the side that was not granted last wins.
            if (req_i && (!req_d || last_gnt == OWN_D)) begin
               state_nx    = ARB_GNT_I;
               last_gnt_nx = OWN_I;
               grant       = 1'b1;
            end else if (req_d) begin
               state_nx    = ARB_GNT_D;
               last_gnt_nx = OWN_D;
               grant       = 1'b1;
            end
         end

         ARB_GNT_I: begin
            // Memory request follows the owner's live inputs; if the owner
            // drops it, the grant is still held until the watchdog fires.
            m_addr = i_addr;
            m_ren  = i_ren;
            if (i_ren && m_rvalid) begin
               xfer_done = 1'b1;
               i_rvalid  = 1'b1;
               i_rdata   = m_rdata;
               state_nx  = ARB_RELEASE;
            end else if (expire) begin
               err_timeout = 1'b1;
               state_nx    = ARB_RELEASE;
            end
         end

         ARB_GNT_D: begin
            // A write takes priority when both D-side enables are high.
            m_addr  = d_addr;
            m_wen   = d_wen;
            m_ren   = d_ren & ~d_wen;
            m_wdata = d_wdata;
            m_wlen  = d_wlen;
            if (d_wen && m_wready) begin
               xfer_done = 1'b1;
               d_wready  = 1'b1;
               state_nx  = ARB_RELEASE;
            end else if (d_ren && !d_wen && m_rvalid) begin
               xfer_done = 1'b1;
               d_rvalid  = 1'b1;
               d_rdata   = m_rdata;
               state_nx  = ARB_RELEASE;
            end else if (expire) begin
               err_timeout = 1'b1;
               state_nx    = ARB_RELEASE;
            end
         end

         ARB_RELEASE: begin
            // Dead cycle so the requester can drop its level request before
            // arbitration looks at it again.
            state_nx = ARB_IDLE;
         end

         default: state_nx = ARB_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter with a transaction-level reference
//   model compared on every falling edge, plus literal expectations for the
//   individual scenarios.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam int ADDR_W  = 32;
   localparam int LINE_W  = 64;
   localparam int WLEN_W  = 2;
   localparam int TIMEOUT = 4;
   localparam int CNT_W   = 3;

   logic              clk = 1'b0;
   logic              rstn;
   logic [ADDR_W-1:0] i_addr;
   logic              i_ren;
   logic [LINE_W-1:0] i_rdata;
   logic              i_rvalid;
   logic [ADDR_W-1:0] d_addr;
   logic              d_ren;
   logic              d_wen;
   logic [LINE_W-1:0] d_wdata;
   logic [WLEN_W-1:0] d_wlen;
   logic [LINE_W-1:0] d_rdata;
   logic              d_rvalid;
   logic              d_wready;
   logic [ADDR_W-1:0] m_addr;
   logic              m_ren;
   logic              m_wen;
   logic [LINE_W-1:0] m_wdata;
   logic [WLEN_W-1:0] m_wlen;
   logic [LINE_W-1:0] m_rdata  = '0;
   logic              m_rvalid = 1'b0;
   logic              m_wready = 1'b0;
   logic              err_timeout;
   logic              busy;

   mem_port_arbiter #(
      .ADDR_W  (ADDR_W),
      .LINE_W  (LINE_W),
      .WLEN_W  (WLEN_W),
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .i_addr      (i_addr),
      .i_ren       (i_ren),
      .i_rdata     (i_rdata),
      .i_rvalid    (i_rvalid),
      .d_addr      (d_addr),
      .d_ren       (d_ren),
      .d_wen       (d_wen),
      .d_wdata     (d_wdata),
      .d_wlen      (d_wlen),
      .d_rdata     (d_rdata),
      .d_rvalid    (d_rvalid),
      .d_wready    (d_wready),
      .m_addr      (m_addr),
      .m_ren       (m_ren),
      .m_wen       (m_wen),
      .m_wdata     (m_wdata),
      .m_wlen      (m_wlen),
      .m_rdata     (m_rdata),
      .m_rvalid    (m_rvalid),
      .m_wready    (m_wready),
      .err_timeout (err_timeout),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------------------------------------------------------------
   // Memory responder: answers on the mem_lat-th cycle of an active request
   // (mem_lat == 0 means never answer). m_rdata always carries mem_data so
   // that gating of the requester-side rdata is visible.
   // ---------------------------------------------------------------------
   int          mem_lat  = 0;
   int          mem_cyc  = 0;
   logic [63:0] mem_data = 64'h0F0F_0F0F_0F0F_0F0F;

   always begin
      @(posedge clk);
      #2;
      if (rstn && (m_ren || m_wen)) begin
         mem_cyc++;
         m_rvalid = m_ren && (mem_lat != 0) && (mem_cyc == mem_lat);
         m_wready = m_wen && (mem_lat != 0) && (mem_cyc == mem_lat);
      end else begin
         mem_cyc  = 0;
         m_rvalid = 1'b0;
         m_wready = 1'b0;
      end
      m_rdata = mem_data;
   end

   // ---------------------------------------------------------------------
   // Reference model: the port is either free, owned by one side for a
   // transaction of some age, or cooling down for one cycle. Expected
   // outputs are derived from that and the live inputs.
   // ---------------------------------------------------------------------
   localparam int P_FREE = 0, P_OWNED = 1, P_COOL = 2;

   int          mdl_phase;
   bit          mdl_own_d;
   bit          mdl_last_d;
   int          mdl_age;

   logic [63:0] e_m_addr, e_m_wdata, e_i_rdata, e_d_rdata;
   logic        e_m_ren, e_m_wen, e_i_rvalid, e_d_rvalid, e_d_wready, e_err, e_busy;
   logic [1:0]  e_m_wlen;
   bit          done;

   always @(negedge clk) begin
      e_m_addr = '0; e_m_wdata = '0; e_m_wlen = '0; e_m_ren = 1'b0; e_m_wen = 1'b0;
      e_i_rdata = '0; e_d_rdata = '0; e_i_rvalid = 1'b0; e_d_rvalid = 1'b0;
      e_d_wready = 1'b0; e_err = 1'b0; e_busy = 1'b0; done = 1'b0;

      if (!rstn) begin
         mdl_phase  = P_FREE;
         mdl_own_d  = 1'b0;
         mdl_last_d = 1'b1;
         mdl_age    = 0;
      end else begin
         e_busy = (mdl_phase != P_FREE);
         if (mdl_phase == P_OWNED) begin
            if (!mdl_own_d) begin
               e_m_addr = 64'(i_addr);
               e_m_ren  = i_ren;
            end else begin
               e_m_addr  = 64'(d_addr);
               e_m_wen   = d_wen;
               e_m_ren   = d_ren && !d_wen;
               e_m_wdata = d_wdata;
               e_m_wlen  = d_wlen;
            end
            if (e_m_ren && m_rvalid) begin
               done = 1'b1;
               if (mdl_own_d) begin e_d_rvalid = 1'b1; e_d_rdata = m_rdata; end
               else           begin e_i_rvalid = 1'b1; e_i_rdata = m_rdata; end
            end else if (e_m_wen && m_wready) begin
               done       = 1'b1;
               e_d_wready = 1'b1;
            end
            e_err = !done && (mdl_age == TIMEOUT - 1);
         end
      end

      check("m_addr",      64'(m_addr),   e_m_addr);
      check("m_ren",       64'(m_ren),    64'(e_m_ren));
      check("m_wen",       64'(m_wen),    64'(e_m_wen));
      check("m_wdata",     m_wdata,       e_m_wdata);
      check("m_wlen",      64'(m_wlen),   64'(e_m_wlen));
      check("i_rvalid",    64'(i_rvalid), 64'(e_i_rvalid));
      check("i_rdata",     i_rdata,       e_i_rdata);
      check("d_rvalid",    64'(d_rvalid), 64'(e_d_rvalid));
      check("d_rdata",     d_rdata,       e_d_rdata);
      check("d_wready",    64'(d_wready), 64'(e_d_wready));
      check("err_timeout", 64'(err_timeout), 64'(e_err));
      check("busy",        64'(busy),     64'(e_busy));

      // Advance to the state the port holds after the coming rising edge.
      if (rstn) begin
         case (mdl_phase)
            P_FREE: begin
               if (i_ren || d_ren || d_wen) begin
                  if (i_ren && (d_ren || d_wen)) mdl_own_d = !mdl_last_d;
                  else                           mdl_own_d = !i_ren;
                  mdl_last_d = mdl_own_d;
                  mdl_age    = 0;
                  mdl_phase  = P_OWNED;
               end
            end
            P_OWNED: begin
               if (done || e_err) mdl_phase = P_COOL;
               else               mdl_age++;
            end
            default: mdl_phase = P_FREE;
         endcase
      end
   end

   // Completion log: 0 = I served, 1 = D served.
   int done_log[$];
   always @(negedge clk) begin
      if (rstn) begin
         if (i_rvalid)             done_log.push_back(0);
         if (d_rvalid || d_wready) done_log.push_back(1);
      end
   end

   // ---------------------------------------------------------------------
   // Directed scenarios. Cycle c0 is the IDLE cycle that sees the request.
   // ---------------------------------------------------------------------
   initial begin
      rstn = 1'b0; i_ren = 1'b0; i_addr = '0; d_ren = 1'b0; d_wen = 1'b0;
      d_addr = '0; d_wdata = '0; d_wlen = '0;
      repeat (3) tick();
      @(negedge clk);
      check("reset_busy",   64'(busy),   64'd0);
      check("reset_m_ren",  64'(m_ren),  64'd0);
      check("reset_m_addr", 64'(m_addr), 64'd0);
      tick();
      rstn = 1'b1;
      tick();

      // I-only read, memory answers on the 3rd granted cycle.
      i_addr = 32'h8000_0040; i_ren = 1'b1; mem_lat = 3; mem_data = 64'hDEAD_BEEF_0123_4567;
      @(negedge clk);
      check("t1_c0_m_ren", 64'(m_ren), 64'd0);
      check("t1_c0_busy",  64'(busy),  64'd0);
      tick(); @(negedge clk);
      check("t1_c1_m_ren",  64'(m_ren),  64'd1);
      check("t1_c1_m_addr", 64'(m_addr), 64'h8000_0040);
      tick(); @(negedge clk);
      check("t1_c2_i_rvalid", 64'(i_rvalid), 64'd0);
      tick(); @(negedge clk);
      check("t1_c3_i_rvalid", 64'(i_rvalid), 64'd1);
      check("t1_c3_i_rdata",  i_rdata,       64'hDEAD_BEEF_0123_4567);
      check("t1_c3_d_rvalid", 64'(d_rvalid), 64'd0);
      tick(); i_ren = 1'b0;
      @(negedge clk);
      check("t1_c4_busy",  64'(busy),  64'd1);
      check("t1_c4_m_ren", 64'(m_ren), 64'd0);
      tick(); @(negedge clk);
      check("t1_c5_busy", 64'(busy), 64'd0);

      // Fresh reset, then both sides request together and stay held.
      tick(); rstn = 1'b0;
      tick(); rstn = 1'b1;
      tick();
      done_log.delete();
      i_addr = 32'h0000_1000; d_addr = 32'h0000_2000; i_ren = 1'b1; d_ren = 1'b1;
      mem_lat = 1; mem_data = 64'hA5A5_5A5A_C3C3_3C3C;
      @(negedge clk);
      check("t2_c0_m_ren", 64'(m_ren), 64'd0);
      tick(); @(negedge clk);
      check("t2_c1_m_addr",   64'(m_addr),   64'h0000_1000);
      check("t2_c1_i_rvalid", 64'(i_rvalid), 64'd1);
      tick(); @(negedge clk);
      check("t2_c2_rel_busy", 64'(busy),  64'd1);
      check("t2_c2_rel_mren", 64'(m_ren), 64'd0);
      tick(); @(negedge clk);
      check("t2_c3_idle_busy", 64'(busy), 64'd0);
      tick(); @(negedge clk);
      check("t2_c4_m_addr",   64'(m_addr),   64'h0000_2000);
      check("t2_c4_d_rvalid", 64'(d_rvalid), 64'd1);
      check("t2_c4_d_rdata",  d_rdata,       64'hA5A5_5A5A_C3C3_3C3C);
      check("t2_c4_i_rvalid", 64'(i_rvalid), 64'd0);
      begin
         int n = 0;
         while (done_log.size() < 8 && n < 200) begin
            tick(); @(negedge clk); #1;
            n++;
         end
      end
      check("t4_served_count", 64'(done_log.size()), 64'd8);
      for (int k = 0; k < 8 && k < done_log.size(); k++)
         check("t4_grant_order", 64'(done_log[k]), 64'(k % 2));
      tick(); i_ren = 1'b0; d_ren = 1'b0;
      tick(); tick();

      // D write with d_ren also high: write wins, completes on 2nd cycle.
      d_addr = 32'h0000_3000; d_wen = 1'b1; d_ren = 1'b1; d_wlen = WLEN_DWORD;
      d_wdata = 64'h1122_3344_5566_7788; mem_lat = 2;
      @(negedge clk);
      check("t3_c0_m_wen", 64'(m_wen), 64'd0);
      tick(); @(negedge clk);
      check("t3_c1_m_wen",   64'(m_wen),   64'd1);
      check("t3_c1_m_ren",   64'(m_ren),   64'd0);
      check("t3_c1_m_wdata", m_wdata,      64'h1122_3344_5566_7788);
      check("t3_c1_m_wlen",  64'(m_wlen),  64'd3);
      check("t3_c1_wready",  64'(d_wready), 64'd0);
      tick(); @(negedge clk);
      check("t3_c2_wready",   64'(d_wready), 64'd1);
      check("t3_c2_m_ren",    64'(m_ren),    64'd0);
      check("t3_c2_d_rvalid", 64'(d_rvalid), 64'd0);
      check("t3_c2_i_rvalid", 64'(i_rvalid), 64'd0);
      tick(); d_wen = 1'b0; d_ren = 1'b0;
      @(negedge clk);
      check("t3_c3_wready", 64'(d_wready), 64'd0);
      check("t3_c3_busy",   64'(busy),     64'd1);
      tick(); tick();

      // Timeout: memory never answers an I read.
      i_addr = 32'h0000_4000; i_ren = 1'b1; mem_lat = 0;
      @(negedge clk);
      check("t5_c0_busy", 64'(busy), 64'd0);
      for (int k = 1; k <= 3; k++) begin
         tick(); @(negedge clk);
         check("t5_early_err", 64'(err_timeout), 64'd0);
      end
      tick(); @(negedge clk);
      check("t5_c4_err",      64'(err_timeout), 64'd1);
      check("t5_c4_i_rvalid", 64'(i_rvalid),    64'd0);
      check("t5_c4_m_ren",    64'(m_ren),       64'd1);
      tick(); i_ren = 1'b0;
      @(negedge clk);
      check("t5_c5_err",  64'(err_timeout), 64'd0);
      check("t5_c5_busy", 64'(busy),        64'd1);
      tick(); @(negedge clk);
      check("t5_c6_busy", 64'(busy), 64'd0);
      tick();

      // Reset asserted while D owns the port.
      d_addr = 32'h0000_5000; d_ren = 1'b1; mem_lat = 0;
      @(negedge clk);
      check("t6_c0_busy", 64'(busy), 64'd0);
      tick(); @(negedge clk);
      check("t6_c1_m_ren",  64'(m_ren),  64'd1);
      check("t6_c1_m_addr", 64'(m_addr), 64'h0000_5000);
      #1 rstn = 1'b0;
      #1;
      check("t6_async_busy",   64'(busy),   64'd0);
      check("t6_async_m_ren",  64'(m_ren),  64'd0);
      check("t6_async_m_addr", 64'(m_addr), 64'd0);
      tick(); tick();
      rstn = 1'b1; i_addr = 32'h0000_6000; i_ren = 1'b1; mem_lat = 1;
      @(negedge clk);
      check("t6_post_c0_busy", 64'(busy), 64'd0);
      tick(); @(negedge clk);
      check("t6_post_c1_m_addr",   64'(m_addr),   64'h0000_6000);
      check("t6_post_c1_i_rvalid", 64'(i_rvalid), 64'd1);
      check("t6_post_c1_d_rvalid", 64'(d_rvalid), 64'd0);
      tick(); i_ren = 1'b0; d_ren = 1'b0;
      repeat (6) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
